// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

    // Controller states; FETCH is encoding 0 so it is also the reset state.
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEXEC,
        S_ADDIWB,
        S_JUMP
    } state_t;

    // Opcode field values (instruction[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Funct field values (instruction[5:0]) for R-type.
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // Coarse ALU operation chosen by the FSM; FUNCT defers to the funct field.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    // ALU control codes understood by the downstream ALU.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU decoder: maps the FSM's aluop plus the funct field to the ALU control word.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int CNTRL_WIDTH = 3,
    parameter int OP_WIDTH    = 6
) (
    input  aluop_t                 i_aluop,
    input  logic [OP_WIDTH-1:0]    i_funct,
    output logic [CNTRL_WIDTH-1:0] o_alucontrol
);

    logic [2:0] w_code;

    // Unknown funct and the reserved aluop both fall back to add.
    always_comb begin
        w_code = ALU_ADD;
        case (i_aluop)
            ALUOP_SUB: w_code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    F_ADD:   w_code = ALU_ADD;
                    F_SUB:   w_code = ALU_SUB;
                    F_AND:   w_code = ALU_AND;
                    F_OR:    w_code = ALU_OR;
                    F_SLT:   w_code = ALU_SLT;
                    default: w_code = ALU_ADD;
                endcase
            end
            default: w_code = ALU_ADD;
        endcase
    end

    assign o_alucontrol = w_code;

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing lw/sw/R-type/beq/addi/j
// and driving every datapath select and write enable.
module mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter int CNTRL_WIDTH = 3,
    parameter int OP_WIDTH    = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [OP_WIDTH-1:0]    i_op,
    input  logic [OP_WIDTH-1:0]    i_funct,
    input  logic                   i_zero,
    output logic                   o_iord,
    output logic                   o_memwrite,
    output logic                   o_irwrite,
    output logic                   o_regdst,
    output logic                   o_memtoreg,
    output logic                   o_regwrite,
    output logic                   o_alusrca,
    output logic [1:0]             o_alusrcb,
    output logic [1:0]             o_pcsrc,
    output logic                   o_pcen,
    output logic [CNTRL_WIDTH-1:0] o_alucontrol
);

    state_t r_state;
    state_t w_next;
    aluop_t w_aluop;
    logic   w_pcwrite;
    logic   w_branch;

    // State register; reset abandons whatever instruction is in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    // Next-state and Moore output decode; reset forces the FETCH selects with all enables off.
    always_comb begin
        w_next     = S_FETCH;
        o_iord     = 1'b0;
        o_memwrite = 1'b0;
        o_irwrite  = 1'b0;
        o_regdst   = 1'b0;
        o_memtoreg = 1'b0;
        o_regwrite = 1'b0;
        o_alusrca  = 1'b0;
        o_alusrcb  = 2'b00;
        o_pcsrc    = 2'b00;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_next    = S_DECODE;
                o_alusrcb = 2'b01;
                o_irwrite = 1'b1;
                w_pcwrite = 1'b1;
            end
            S_DECODE: begin
                o_alusrcb = 2'b11;
                case (i_op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_next    = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_next = S_MEMWB;
                o_iord = 1'b1;
            end
            S_MEMWB: begin
                o_memtoreg = 1'b1;
                o_regwrite = 1'b1;
            end
            S_MEMWR: begin
                o_iord     = 1'b1;
                o_memwrite = 1'b1;
            end
            S_EXECUTE: begin
                w_next    = S_ALUWB;
                o_alusrca = 1'b1;
                w_aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_regdst   = 1'b1;
                o_regwrite = 1'b1;
            end
            S_BRANCH: begin
                o_alusrca = 1'b1;
                w_aluop   = ALUOP_SUB;
                o_pcsrc   = 2'b01;
                w_branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                w_next    = S_ADDIWB;
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                o_regwrite = 1'b1;
            end
            S_JUMP: begin
                o_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        if (!i_rst_n) begin
            o_iord     = 1'b0;
            o_memwrite = 1'b0;
            o_irwrite  = 1'b0;
            o_regdst   = 1'b0;
            o_memtoreg = 1'b0;
            o_regwrite = 1'b0;
            o_alusrca  = 1'b0;
            o_alusrcb  = 2'b01;
            o_pcsrc    = 2'b00;
            w_pcwrite  = 1'b0;
            w_branch   = 1'b0;
            w_aluop    = ALUOP_ADD;
        end
    end

    // zero only reaches pcen, and only while BRANCH has w_branch set.
    assign o_pcen = w_pcwrite | (w_branch & i_zero);

    alu_decoder #(
        .CNTRL_WIDTH (CNTRL_WIDTH),
        .OP_WIDTH    (OP_WIDTH)
    ) u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct      (i_funct),
        .o_alucontrol (o_alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues the expected output
// vector for each cycle, a negedge monitor pops and compares.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    mc_controller dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_op         (op),
        .i_funct      (funct),
        .i_zero       (zero),
        .o_iord       (iord),
        .o_memwrite   (memwrite),
        .o_irwrite    (irwrite),
        .o_regdst     (regdst),
        .o_memtoreg   (memtoreg),
        .o_regwrite   (regwrite),
        .o_alusrca    (alusrca),
        .o_alusrcb    (alusrcb),
        .o_pcsrc      (pcsrc),
        .o_pcen       (pcen),
        .o_alucontrol (alucontrol)
    );

    always #5 clk = ~clk;

    // Expected-state tags (bench-local, independent of the RTL encoding).
    localparam int T_FETCH = 0,  T_DECODE = 1,  T_MEMADR = 2,   T_MEMRD = 3;
    localparam int T_MEMWB = 4,  T_MEMWR = 5,   T_EXECUTE = 6,  T_ALUWB = 7;
    localparam int T_BRANCH = 8, T_ADDIEX = 9,  T_ADDIWB = 10,  T_JUMP = 11;
    localparam int T_RESET = 12;

    typedef struct {
        logic [14:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Vector layout: iord memwrite irwrite regdst memtoreg regwrite alusrca | alusrcb | pcsrc | pcen | alucontrol
    function automatic logic [14:0] expv(input int st, input logic z, input logic [2:0] ac);
        case (st)
            T_FETCH:   return 15'b0010000_01_00_1_010;
            T_DECODE:  return 15'b0000000_11_00_0_010;
            T_MEMADR:  return 15'b0000001_10_00_0_010;
            T_MEMRD:   return 15'b1000000_00_00_0_010;
            T_MEMWB:   return 15'b0000110_00_00_0_010;
            T_MEMWR:   return 15'b1100000_00_00_0_010;
            T_EXECUTE: return {11'b0000001_00_00, 1'b0, ac};
            T_ALUWB:   return 15'b0001010_00_00_0_010;
            T_BRANCH:  return {11'b0000001_00_01, z, 3'b110};
            T_ADDIEX:  return 15'b0000001_10_00_0_010;
            T_ADDIWB:  return 15'b0000010_00_00_0_010;
            T_JUMP:    return 15'b0000000_00_10_1_010;
            default:   return 15'b0000000_01_00_0_010;
        endcase
    endfunction

    function automatic logic [14:0] actual();
        return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, pcen, alucontrol};
    endfunction

    // One clock of stimulus plus its expected response.
    task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input int st, input logic [2:0] ac, input string nm);
        @(posedge clk);
        #1;
        rst_n = r;
        op    = o;
        funct = f;
        zero  = z;
        q.push_back('{expv(st, z, ac), nm});
    endtask

    task automatic rtype(input logic [5:0] f, input logic [2:0] ac, input string nm);
        step(1'b1, 6'b000000, f, 1'b0, T_FETCH,   3'b010, {nm, "_fetch"});
        step(1'b1, 6'b000000, f, 1'b0, T_DECODE,  3'b010, {nm, "_decode"});
        step(1'b1, 6'b000000, f, 1'b0, T_EXECUTE, ac,     {nm, "_execute"});
        step(1'b1, 6'b000000, f, 1'b0, T_ALUWB,   3'b010, {nm, "_aluwb"});
    endtask

    // Monitor: every cycle the DUT presents a control vector; compare against the queue head.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [14:0] a;
            e = q.pop_front();
            a = actual();
            n_total++;
            if (a === e.v) n_pass++;
            else $display("FAIL %s: got %b expected %b", e.name, a, e.v);
        end
    end

    initial begin
        // Reset held three cycles: all enables low, FETCH selects.
        for (int i = 0; i < 3; i++)
            step(1'b0, 6'b100011, 6'd0, 1'b0, T_RESET, 3'b010, "reset");

        // lw: 5 cycles
        step(1'b1, 6'b100011, 6'd0, 1'b0, T_FETCH,  3'b010, "lw_fetch");
        step(1'b1, 6'b100011, 6'd0, 1'b0, T_DECODE, 3'b010, "lw_decode");
        step(1'b1, 6'b100011, 6'd0, 1'b0, T_MEMADR, 3'b010, "lw_memadr");
        step(1'b1, 6'b100011, 6'd0, 1'b0, T_MEMRD,  3'b010, "lw_memrd");
        step(1'b1, 6'b100011, 6'd0, 1'b0, T_MEMWB,  3'b010, "lw_memwb");

        // R-type variants, including an unlisted funct that still writes back as add
        rtype(6'b100010, 3'b110, "sub");
        rtype(6'b101010, 3'b111, "slt");
        rtype(6'b100100, 3'b000, "and");
        rtype(6'b100101, 3'b001, "or");
        rtype(6'b100000, 3'b010, "add");
        rtype(6'b100111, 3'b010, "nor_unlisted");

        // beq taken; zero held high earlier to show it only matters in BRANCH
        step(1'b1, 6'b000100, 6'd0, 1'b1, T_FETCH,  3'b010, "beq1_fetch");
        step(1'b1, 6'b000100, 6'd0, 1'b1, T_DECODE, 3'b010, "beq1_decode");
        step(1'b1, 6'b000100, 6'd0, 1'b1, T_BRANCH, 3'b010, "beq1_branch");
        // beq not taken
        step(1'b1, 6'b000100, 6'd0, 1'b1, T_FETCH,  3'b010, "beq0_fetch");
        step(1'b1, 6'b000100, 6'd0, 1'b1, T_DECODE, 3'b010, "beq0_decode");
        step(1'b1, 6'b000100, 6'd0, 1'b0, T_BRANCH, 3'b010, "beq0_branch");

        // addi
        step(1'b1, 6'b001000, 6'd0, 1'b0, T_FETCH,  3'b010, "addi_fetch");
        step(1'b1, 6'b001000, 6'd0, 1'b0, T_DECODE, 3'b010, "addi_decode");
        step(1'b1, 6'b001000, 6'd0, 1'b0, T_ADDIEX, 3'b010, "addi_exec");
        step(1'b1, 6'b001000, 6'd0, 1'b0, T_ADDIWB, 3'b010, "addi_wb");

        // j
        step(1'b1, 6'b000010, 6'd0, 1'b0, T_FETCH,  3'b010, "j_fetch");
        step(1'b1, 6'b000010, 6'd0, 1'b0, T_DECODE, 3'b010, "j_decode");
        step(1'b1, 6'b000010, 6'd0, 1'b0, T_JUMP,   3'b010, "j_jump");

        // illegal op: two cycles, no enables beyond FETCH
        step(1'b1, 6'b111111, 6'd0, 1'b0, T_FETCH,  3'b010, "ill_fetch");
        step(1'b1, 6'b111111, 6'd0, 1'b0, T_DECODE, 3'b010, "ill_decode");

        // sw interrupted by reset at MEMADR, then a clean sw
        step(1'b1, 6'b101011, 6'd0, 1'b0, T_FETCH,  3'b010, "swr_fetch");
        step(1'b1, 6'b101011, 6'd0, 1'b0, T_DECODE, 3'b010, "swr_decode");
        step(1'b0, 6'b101011, 6'd0, 1'b0, T_RESET,  3'b010, "swr_reset_at_memadr");
        step(1'b1, 6'b101011, 6'd0, 1'b0, T_FETCH,  3'b010, "sw_fetch");
        step(1'b1, 6'b101011, 6'd0, 1'b0, T_DECODE, 3'b010, "sw_decode");
        step(1'b1, 6'b101011, 6'd0, 1'b0, T_MEMADR, 3'b010, "sw_memadr");
        step(1'b1, 6'b101011, 6'd0, 1'b0, T_MEMWR,  3'b010, "sw_memwr");
        step(1'b1, 6'b000000, 6'd0, 1'b0, T_FETCH,  3'b010, "sw_return_fetch");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
